// File: rtl/raster_to_blocks.sv
// raster_to_blocks: converts raster-order pixel beats into BLK x BLK block order.
// Two band buffers alternate between filling (write side) and draining
// (read side); the read side streams blocks through a two-stage pipeline
// (RAM read register, then output register) that stalls on blk_ready.
module raster_to_blocks #(
    parameter int N     = 2,
    parameter int CH    = 3,
    parameter int BLK   = 8,
    parameter int MAX_X = 2160
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [$clog2(MAX_X+1)-1:0]   x_res,
    input  logic                         hdmi_v_sync,
    input  logic                         hdmi_h_sync,
    input  logic                         hdmi_data_valid,
    input  logic [N*CH*8-1:0]            hdmi_data,
    output logic                         blk_valid,
    input  logic                         blk_ready,
    output logic [N*CH*8-1:0]            blk_data,
    output logic                         blk_sob,
    output logic                         blk_eob,
    output logic                         blk_sof,
    output logic                         ovf
);

    localparam int W     = N*CH*8;
    localparam int DEPTH = BLK*MAX_X/N;
    localparam int AW    = $clog2(DEPTH);
    localparam int XW    = $clog2(MAX_X+1);
    localparam int BPB   = BLK/N;
    localparam int EW    = (BPB > 1) ? $clog2(BPB) : 1;
    localparam int LW    = $clog2(BLK);
    localparam int NS    = $clog2(N);
    localparam int BS    = $clog2(BLK);

    typedef enum logic [1:0] {EMPTY, FILLING, DRAINING} buf_state_t;

    // h_sync carries no addressing information; lines are counted by beats
    logic unused_h_sync;
    assign unused_h_sync = hdmi_h_sync;

    logic [W-1:0]  mem [2][DEPTH];
    buf_state_t    buf_state [2];
    logic          buf_sof [2];
    logic [AW-1:0] buf_stride [2];
    logic [XW-1:0] buf_nblk [2];

    logic          wr_buf;
    logic [AW-1:0] wr_addr;
    logic [XW-1:0] x_res_l;
    logic          sof_pending;

    logic          rd_buf;
    logic [EW-1:0] rd_elem;
    logic [LW-1:0] rd_line;
    logic [XW-1:0] rd_blk;

    logic          s1_valid, s1_sob, s1_eob, s1_sof;
    logic [W-1:0]  s1_data;

    // write-side decode; a v_sync beat restarts the band at address 0
    logic          accept, wr_en, wr_last;
    logic [AW-1:0] wr_ptr, stride_l;
    logic [AW:0]   band_words;

    assign accept     = en & hdmi_data_valid;
    assign wr_en      = accept && (buf_state[wr_buf] != DRAINING);
    assign wr_ptr     = hdmi_v_sync ? '0 : wr_addr;
    assign stride_l   = AW'(x_res_l >> NS);
    assign band_words = (AW+1)'(stride_l) << BS;
    assign wr_last    = !hdmi_v_sync && ({1'b0, wr_addr} == band_words - 1'b1);

    // read-side decode; each draining band uses the width it was filled with
    logic          elem_last, line_last, blk_last;
    logic          out_ready, s1_ready, rd_issue, rd_done;
    logic [AW-1:0] rd_addr;

    assign rd_addr   = AW'(rd_elem) + AW'(rd_line) * buf_stride[rd_buf] + AW'(rd_blk) * AW'(BPB);
    assign elem_last = (rd_elem == EW'(BPB-1));
    assign line_last = (rd_line == LW'(BLK-1));
    assign blk_last  = (rd_blk == buf_nblk[rd_buf] - 1'b1);
    assign out_ready = !blk_valid || blk_ready;
    assign s1_ready  = !s1_valid || out_ready;
    assign rd_issue  = (buf_state[rd_buf] == DRAINING) && s1_ready;
    assign rd_done   = rd_issue && elem_last && line_last && blk_last;

    // band RAM: write port from the raster side, registered read port
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_buf][wr_ptr] <= hdmi_data;
        if (rd_issue)
            s1_data <= mem[rd_buf][rd_addr];
    end

    // buffer ownership, write pointer, frame control and overflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_buf        <= 1'b0;
            wr_addr       <= '0;
            x_res_l       <= XW'(MAX_X);
            sof_pending   <= 1'b0;
            ovf           <= 1'b0;
            buf_state[0]  <= EMPTY;
            buf_state[1]  <= EMPTY;
            buf_sof[0]    <= 1'b0;
            buf_sof[1]    <= 1'b0;
            buf_stride[0] <= '0;
            buf_stride[1] <= '0;
            buf_nblk[0]   <= '0;
            buf_nblk[1]   <= '0;
        end else begin
            if (hdmi_v_sync) begin
                x_res_l     <= x_res;
                wr_addr     <= '0;
                sof_pending <= 1'b1;
                ovf         <= 1'b0;
                if (buf_state[wr_buf] == FILLING)
                    buf_state[wr_buf] <= EMPTY;
            end
            // a drop in the v_sync cycle belongs to the new frame, so it wins
            if (accept && !wr_en)
                ovf <= 1'b1;
            if (wr_en) begin
                if (wr_ptr == '0) begin
                    buf_sof[wr_buf] <= hdmi_v_sync | sof_pending;
                    sof_pending     <= 1'b0;
                end
                if (wr_last) begin
                    buf_state[wr_buf]  <= DRAINING;
                    buf_stride[wr_buf] <= stride_l;
                    buf_nblk[wr_buf]   <= x_res_l >> BS;
                    wr_addr            <= '0;
                    wr_buf             <= ~wr_buf;
                end else begin
                    buf_state[wr_buf] <= FILLING;
                    wr_addr           <= wr_ptr + 1'b1;
                end
            end
            // the reader only ever frees a DRAINING buffer, never the writer's
            if (rd_done)
                buf_state[rd_buf] <= EMPTY;
        end
    end

    // read counters: beat within line, line within block, block within band
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_buf  <= 1'b0;
            rd_elem <= '0;
            rd_line <= '0;
            rd_blk  <= '0;
        end else if (rd_issue) begin
            if (elem_last) begin
                rd_elem <= '0;
                if (line_last) begin
                    rd_line <= '0;
                    if (blk_last) begin
                        rd_blk <= '0;
                        rd_buf <= ~rd_buf;
                    end else begin
                        rd_blk <= rd_blk + 1'b1;
                    end
                end else begin
                    rd_line <= rd_line + 1'b1;
                end
            end else begin
                rd_elem <= rd_elem + 1'b1;
            end
        end
    end

    // pipeline: markers travel beside the RAM read, then into the output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_sob    <= 1'b0;
            s1_eob    <= 1'b0;
            s1_sof    <= 1'b0;
            blk_valid <= 1'b0;
            blk_data  <= '0;
            blk_sob   <= 1'b0;
            blk_eob   <= 1'b0;
            blk_sof   <= 1'b0;
        end else begin
            if (s1_ready) begin
                s1_valid <= rd_issue;
                s1_sob   <= (rd_elem == '0) && (rd_line == '0);
                s1_eob   <= elem_last && line_last;
                s1_sof   <= (rd_elem == '0) && (rd_line == '0) && (rd_blk == '0) && buf_sof[rd_buf];
            end
            if (out_ready) begin
                blk_valid <= s1_valid;
                blk_sob   <= s1_valid & s1_sob;
                blk_eob   <= s1_valid & s1_eob;
                blk_sof   <= s1_valid & s1_sof;
                if (s1_valid)
                    blk_data <= s1_data;
            end
        end
    end

endmodule

// File: doc/raster_to_blocks.md
RASTER_TO_BLOCKS -- requirements
Module: raster_to_blocks

Interface
REQ-001 Parameter N, default 2: pixels per input beat; legal values 1, 2, 4, 8; N SHALL divide BLK.
REQ-002 Parameter CH, default 3: channels per pixel, 8 bits each; legal values 1 to 4.
REQ-003 Parameter BLK, default 8: block height and width in pixels; legal values 8, 16.
REQ-004 Parameter MAX_X, default 2160: largest supported line width in pixels; multiple of BLK.
REQ-005 clk  in  1  sole clock; all logic rising-edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 en  in  1  write-side enable; 0 ignores input beats.
REQ-008 x_res  in  clog2(MAX_X+1)  active line width in pixels; multiple of BLK, at most MAX_X; sampled only at v_sync.
REQ-009 hdmi_v_sync  in  1  frame start pulse.
REQ-010 hdmi_h_sync  in  1  line start; informational, not used for addressing.
REQ-011 hdmi_data_valid  in  1  input beat qualifier.
REQ-012 hdmi_data  in  N*CH*8  pixels; channel c of pixel p at bits [(c*N+p)*8 +: 8].
REQ-013 blk_valid  out  1  output beat valid.
REQ-014 blk_ready  in  1  downstream accept; a beat transfers when valid and ready are both 1.
REQ-015 blk_data  out  N*CH*8  output pixels; same packing as hdmi_data.
REQ-016 blk_sob / blk_eob / blk_sof  out  1 each  first beat of block / last beat of block / first beat of frame.
REQ-017 ovf  out  1  sticky overflow flag.

Function
REQ-018 Two band buffers, each BLK*MAX_X/N words; every buffer SHALL be in state EMPTY, FILLING or DRAINING.
REQ-019 Write side: each accepted beat (en=1, valid=1) SHALL be written at wr_addr in the write buffer, then wr_addr increments.
REQ-020 When wr_addr reaches BLK*x_res_l/N-1, where x_res_l is the latched width: that buffer SHALL become DRAINING, wr_addr SHALL return to 0, and writing SHALL toggle to the other buffer.
REQ-021 A beat whose target buffer is DRAINING SHALL be dropped without any write and SHALL set ovf; wr_addr SHALL hold.
REQ-022 Read order within a band: blocks left to right; within a block, lines top to bottom; within a line, beats left to right.
REQ-023 Read address SHALL be elem + line*(x_res_l/N) + blk*(BLK/N), computed with at least clog2(BLK*MAX_X/N) bits.
REQ-024 Read side SHALL drain the DRAINING buffer with the older fill first; after the last beat of block x_res_l/BLK-1 it SHALL mark that buffer EMPTY.
REQ-025 RAM read latency is 1 cycle; the output register stage SHALL give first blk_valid exactly 2 cycles after the band-complete write when blk_ready=1.
REQ-026 With blk_ready=0, blk_valid and blk_data SHALL hold. No beat SHALL be lost or duplicated, which requires a 2-entry skid or a read-address stall.
REQ-027 With sustained blk_ready=1, the output SHALL deliver 1 beat per cycle.
REQ-028 blk_sob SHALL be 1 when elem=0 and line=0; blk_eob SHALL be 1 when elem=BLK/N-1 and line=BLK-1.
REQ-029 blk_sof SHALL be 1 on blk_sob of the first block of the first band written after hdmi_v_sync.
REQ-030 hdmi_v_sync SHALL: latch x_res, reset wr_addr to 0 and discard any partially FILLING band, set sof-pending, and clear ovf. Bands already DRAINING SHALL finish normally.
REQ-031 If v_sync and an accepted beat occur in the same cycle, the beat SHALL be written as the first beat of the new frame.
REQ-032 If a band completes on the same cycle the reader frees the other buffer, the writer SHALL proceed with no drop.

Reset
REQ-033 While rst=1: blk_valid, blk_data, blk_sob, blk_eob, blk_sof and ovf SHALL be 0, both buffers EMPTY, all counters 0, x_res_l=MAX_X, sof-pending 0.
REQ-034 Reset asserted mid-band SHALL abandon all buffered data. RAM contents need no reset.
REQ-035 First accepted beat after rst deasserts SHALL go to buffer 0, address 0.

Verification
REQ-036 N=2, BLK=8, x_res=32, ramp data, ready=1 -> 128 beats out in block order; first beat pixels (0,1), second beat (2,3), fifth beat row 1 pixels 0-1; eob every 32 beats.
REQ-037 Same setup, blk_ready toggled pseudo-randomly at 50% -> output sequence identical to the ready=1 run; no gaps while ready=1 and data is buffered.
REQ-038 blk_ready=0 held for 3 bands -> third band dropped, ovf=1; next v_sync -> ovf=0.
REQ-039 v_sync at beat 40 of a band, x_res changed 32->64 -> partial band discarded; next band 256 beats; first sob carries blk_sof=1.
REQ-040 rst pulsed while blk_valid=1 -> all outputs 0 on the next edge, asynchronously; clean restart at buffer 0.
REQ-041 N=4, CH=1, BLK=16, x_res=MAX_X -> eob every 64 beats; address never exceeds BLK*MAX_X/N-1.
